add_seq_ctrl: RTL and testbench

//  Multi-precision add/subtract sequencer: time-multiplexes one 8-bit ripple adder slice

---
 rtl/add_seq_ctrl_pkg.sv | 11 +
 rtl/yAdder.sv | 23 ++
 rtl/add_seq_ctrl.sv | 107 ++++++++++
 tb/tb_add_seq_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer:
// slice width and FSM state encoding.
package add_seq_ctrl_pkg;

   localparam int SLICE_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/yAdder.sv
// 8-bit ripple-carry adder slice: z = a + b + cin, cout from the MSB.
module yAdder
   import add_seq_ctrl_pkg::*;
(
   output logic [SLICE_W-1:0] z,
   output logic               cout,
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin
);

   logic [SLICE_W:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign z[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign cout = w_c[SLICE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one 8-bit slice reused over WORDS
// cycles, carry held in a flop between slices, valid/ready on both sides.
module add_seq_ctrl
   import add_seq_ctrl_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SLICE_W*WORDS-1:0]   a,
   input  logic [SLICE_W*WORDS-1:0]   b,
   input  logic                       sub,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SLICE_W*WORDS-1:0]   z,
   output logic                       cout,
   output logic                       ovf,
   output logic                       busy
);

   localparam int W     = SLICE_W * WORDS;
   localparam int IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   logic [1:0]         r_state;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_z;
   logic               r_sub;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;
   logic [IDX_W-1:0]   r_idx;

   logic [SLICE_W-1:0] w_a_sl;
   logic [SLICE_W-1:0] w_b_sl;
   logic [SLICE_W-1:0] w_sum;
   logic               w_cout;

   // Subtraction is A + ~B + 1: the +1 enters as the first slice carry-in.
   assign w_a_sl = r_a[r_idx*SLICE_W +: SLICE_W];
   assign w_b_sl = r_b[r_idx*SLICE_W +: SLICE_W] ^ {SLICE_W{r_sub}};

   yAdder u_slice (
      .z    (w_sum),
      .cout (w_cout),
      .a    (w_a_sl),
      .b    (w_b_sl),
      .cin  (r_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_z     <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_sub   <= sub;
                  r_carry <= sub;
                  r_idx   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_z[r_idx*SLICE_W +: SLICE_W] <= w_sum;
               r_carry <= w_cout;
               r_idx   <= r_idx + IDX_W'(1);
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_cout  <= w_cout;
                  // Signed overflow: equal operand signs but result sign differs.
                  r_ovf   <= (w_a_sl[SLICE_W-1] == w_b_sl[SLICE_W-1]) &&
                             (w_sum[SLICE_W-1] != w_a_sl[SLICE_W-1]);
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);
   assign z         = r_z;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (WORDS=4): directed vector table,
// backpressure and mid-run reset sequences, then random ops against a model.
module tb_add_seq_ctrl;

   localparam int WORDS = 4;
   localparam int W     = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  z;
   logic          cout;
   logic          ovf;
   logic          busy;

   always #5 clk = ~clk;

   add_seq_ctrl #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] z;
      logic         cout;
      logic         ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] z;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Independent golden model: signed range test for overflow, unsigned compare for borrow.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
      exp_t        e;
      longint      sa;
      longint      sbv;
      longint      r;
      logic [W:0]  u;
      sa  = longint'($signed(ma));
      sbv = longint'($signed(mb));
      r   = ms ? (sa - sbv) : (sa + sbv);
      u   = {1'b0, ma} + {1'b0, mb};
      e.z    = ms ? (ma - mb) : (ma + mb);
      e.cout = ms ? (ma >= mb) : u[W];
      e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      return e;
   endfunction

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                        input exp_t e);
      @(negedge clk);
      check("in_ready_before_accept", in_ready, 1'b1);
      a        = ia;
      b        = ib;
      sub      = is;
      in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      sub      = 1'($urandom_range(0, 1));
   endtask

   task automatic collect(input int hold);
      int   n;
      exp_t e;
      n = 0;
      while (n < 20 && !out_valid) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 64'(n), 64'(WORDS));
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a        = 32'hDEADBEEF;
         b        = 32'h00000001;
         @(posedge clk);
         #1;
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_z_stable", z, e.z);
      end
      in_valid = 1'b0;
      check("z", z, e.z);
      check("cout", cout, e.cout);
      check("ovf", ovf, e.ovf);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 1'b0);
      check("in_ready_return", in_ready, 1'b1);
      if (hold > 0) begin
         check("z_not_overwritten", z, e.z);
         check("busy_idle", busy, 1'b0);
      end
   endtask

   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                        input exp_t e);
      issue(ia, ib, is, e);
      collect(0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl[7];
      exp_t         e;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;

      tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
      tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
      tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
      tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
      tbl[5] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
      tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      #12;
      check("rst_z", z, 32'h0);
      check("rst_cout", cout, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1'b1);

      for (int i = 0; i < 7; i++) begin
         e.z    = tbl[i].z;
         e.cout = tbl[i].cout;
         e.ovf  = tbl[i].ovf;
         do_op(tbl[i].a, tbl[i].b, tbl[i].sub, e);
      end

      // Backpressure: hold DONE for 10 cycles with a competing request.
      e = '{32'h11223344, 1'b0, 1'b0};
      issue(32'h01020304, 32'h10203040, 1'b0, e);
      collect(10);

      // Asynchronous reset while idx==2 in RUN.
      @(negedge clk);
      a        = 32'hAAAAAAAA;
      b        = 32'h11111111;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("pre_abort_busy", busy, 1'b1);
      check("pre_abort_low_bytes", 64'(z[15:0]), 64'h0000BBBB);
      rst_n = 1'b0;
      #1;
      check("abort_z", z, 32'h0);
      check("abort_busy", busy, 1'b0);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_cout", cout, 1'b0);
      check("abort_ovf", ovf, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 1'b1);
      e = '{32'h23456789, 1'b0, 1'b0};
      do_op(32'h12345678, 32'h11111111, 1'b0, e);

      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (i % 50 == 0) rb = ra;
         do_op(ra, rb, rs, model(ra, rb, rs));
      end

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
